blocking_fanout_buffer: RTL and testbench
=========================================

# blocking_fanout_buffer

Parametrised successor to the single-port section skeletons. Accepts words on one blocking input port, tags each with a destination set chosen by master-input control (unicast, broadcast, round-robin, drop), buffers up to DEPTH entries, and delivers each entry on NUM_CH blocking output ports using the sync/notify handshake. Sits between a producer module and several consumer modules in generated top-level designs.

## Interface
- DATA_W, 32, payload width
- NUM_CH, 4, number of blocking output channels (2..16)
- DEPTH, 4, FIFO entries (power of two, ≥2)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- b_in  in  DATA_W  input payload
- b_in_sync  in  1  producer offers b_in
- b_in_notify  out  1  block ready to accept
- m_in_mode  in  2  master input: 0 unicast, 1 broadcast, 2 round-robin, 3 drop
- m_in_chan  in  $clog2(NUM_CH)  unicast destination
- b_out  out  NUM_CH×DATA_W  per-channel payload (all carry head data)
- b_out_sync  in  NUM_CH  consumer ready per channel
- b_out_notify  out  NUM_CH  block offers data per channel
- level  out  $clog2(DEPTH+1)  FIFO occupancy
- drop_cnt  out  16  saturating count of dropped words

## Operation
- Transfer on any port occurs at a rising edge where sync and notify are both 1.
- Input accept: m_in_mode/m_in_chan sampled at the accept edge and converted to a NUM_CH-bit mask: unicast → one-hot(m_in_chan); broadcast → all ones; round-robin → one-hot(rr_ptr), then rr_ptr increments, NUM_CH-1 wraps to 0; drop → zero.
- Zero mask or unicast with m_in_chan ≥ NUM_CH: word consumed, not stored, drop_cnt += 1 (saturates at 16'hFFFF). Otherwise {data, mask} pushed.
- b_in_notify registered: next value = (next occupancy < DEPTH).
- Output FSM states: S_EMPTY, S_ISSUE.
  - S_EMPTY: if FIFO non-empty at an edge, load head mask into pending, go S_ISSUE.
  - S_ISSUE: b_out_notify = pending; each channel bit clears on its handshake edge. When the last pending bit clears: pop; if another entry exists, load its mask into pending same edge (stay S_ISSUE), else go S_EMPTY.
- Broadcast channels complete independently and in any order; the entry is retired only after all have handshaked.
- b_out[c] = head data for all c; valid only where b_out_notify[c]=1.
- Simultaneous push and pop: occupancy unchanged; push into full FIFO never occurs (notify low).

## Timing
- Reset values: b_in_notify=1, b_out_notify=0, b_out=0, level=0, drop_cnt=0, rr_ptr=0, state S_EMPTY, FIFO empty.
- Reset asserted mid-transfer: all buffered and pending data discarded immediately; no partial handshake completes.
- Latency: accept at edge k → b_out_notify high from edge k+1 (FSM loads at k+1 when FIFO was empty).
- Throughput: one entry per cycle when every targeted consumer holds sync=1.
- Full: after DEPTH accepts with no retire, b_in_notify low the next cycle; a retire restores it one cycle later.
- level updates on the same edge as push/pop.

## Test plan
- Unicast chan=2, data 0xA5A5_0001, b_out_sync=4'b0100 → b_out_notify=4'b0100 one cycle after accept, retire next edge, level back to 0.
- Broadcast 0x1234 with sync per channel staggered over 4 cycles → each notify bit drops after its own handshake; b_in words behind it stall at head until last channel done.
- Round-robin 6 words, all sync=1 → delivered to channels 0,1,2,3,0,1 in order; rr_ptr=2 at end.
- Fill: all b_out_sync=0, offer 5 words (DEPTH=4) → 4 accepted, b_in_notify=0, level=4; release one channel → notify returns 1 one cycle after retire.
- Drop mode and unicast chan out-of-range → no output activity, drop_cnt=2; force 70000 drops → drop_cnt holds 16'hFFFF.
- Assert rst low with 3 entries buffered and notify high → outputs reset immediately; after release, level=0, b_in_notify=1.

Source files
------------

// File: rtl/blocking_fanout_buffer.sv
// Blocking-input FIFO that fans each buffered word out to a per-entry set of
// blocking output channels; an entry retires once every targeted channel has taken it.
module blocking_fanout_buffer #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_W-1:0]            b_in,
  input  logic                         b_in_sync,
  output logic                         b_in_notify,
  input  logic [1:0]                   m_in_mode,
  input  logic [$clog2(NUM_CH)-1:0]    m_in_chan,
  output logic [NUM_CH*DATA_W-1:0]     b_out,
  input  logic [NUM_CH-1:0]            b_out_sync,
  output logic [NUM_CH-1:0]            b_out_notify,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [15:0]                  drop_cnt
);

  localparam int CW = $clog2(NUM_CH);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  localparam logic [1:0] MODE_UNI  = 2'd0;
  localparam logic [1:0] MODE_BC   = 2'd1;
  localparam logic [1:0] MODE_RR   = 2'd2;

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [NUM_CH-1:0] mask_mem [DEPTH];

  logic [0:0]        state_reg, state_next;
  logic [NUM_CH-1:0] pending_reg, pending_next;
  logic [DATA_W-1:0] head_data_reg;
  logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg, load_addr;
  logic [LW-1:0]     count_reg, count_next;
  logic              notify_reg;
  logic [CW-1:0]     rr_ptr_reg;
  logic [15:0]       drop_cnt_reg;

  logic [NUM_CH-1:0] in_mask, hs, pending_left;
  logic              in_fire, push, drop, pop, load;

  // Destination set for the word on offer; an out-of-range unicast yields
  // an empty set and is therefore counted as a drop.
  always_comb begin
    in_mask = '0;
    case (m_in_mode)
      MODE_UNI: if (32'(m_in_chan) < NUM_CH) in_mask[m_in_chan] = 1'b1;
      MODE_BC:  in_mask = '1;
      MODE_RR:  in_mask[rr_ptr_reg] = 1'b1;
      default:  in_mask = '0;
    endcase
  end

  assign in_fire      = b_in_sync & notify_reg;
  assign push         = in_fire & (|in_mask);
  assign drop         = in_fire & ~(|in_mask);
  assign b_out_notify = (state_reg == S_ISSUE) ? pending_reg : '0;
  assign hs           = b_out_sync & b_out_notify;
  assign pending_left = pending_reg & ~hs;
  assign pop          = (state_reg == S_ISSUE) && (pending_left == '0);

  // The next head is loaded from memory either when leaving S_EMPTY or when
  // retiring an entry that already has a successor in the FIFO.
  assign load      = ((state_reg == S_EMPTY) && (count_reg != '0)) ||
                     (pop && (count_reg > LW'(1)));
  assign load_addr = (state_reg == S_EMPTY) ? rd_ptr_reg : rd_ptr_reg + AW'(1);

  assign count_next = count_reg + LW'(push) - LW'(pop);

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    if (state_reg == S_EMPTY) begin
      if (count_reg != '0) state_next = S_ISSUE;
    end else begin
      pending_next = pending_left;
      if (pop && (count_reg == LW'(1))) state_next = S_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_reg] <= b_in;
      mask_mem[wr_ptr_reg] <= in_mask;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_EMPTY;
      pending_reg   <= '0;
      head_data_reg <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      notify_reg    <= 1'b1;
      rr_ptr_reg    <= '0;
      drop_cnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        pending_reg   <= mask_mem[load_addr];
        head_data_reg <= data_mem[load_addr];
      end else begin
        pending_reg   <= pending_next;
      end
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg  <= count_next;
      notify_reg <= (count_next < LW'(DEPTH));
      if (in_fire && (m_in_mode == MODE_RR))
        rr_ptr_reg <= (rr_ptr_reg == CW'(NUM_CH-1)) ? '0 : rr_ptr_reg + CW'(1);
      if (drop && (drop_cnt_reg != 16'hFFFF))
        drop_cnt_reg <= drop_cnt_reg + 16'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_out
      assign b_out[gi*DATA_W +: DATA_W] = head_data_reg;
    end
  endgenerate

  assign b_in_notify = notify_reg;
  assign level       = count_reg;
  assign drop_cnt    = drop_cnt_reg;

endmodule

// File: tb/tb_blocking_fanout_buffer.sv
// Directed bench: entry-level scoreboard checked by a negedge monitor, plus
// direct checks of latency, full/backpressure, drop counting and reset.
module tb_blocking_fanout_buffer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  b_in = '0;
  logic         b_in_sync = 1'b0;
  logic         b_in_notify;
  logic [1:0]   m_in_mode = '0;
  logic [1:0]   m_in_chan = '0;
  logic [127:0] b_out;
  logic [3:0]   b_out_sync = '0;
  logic [3:0]   b_out_notify;
  logic [2:0]   level;
  logic [15:0]  drop_cnt;

  // Three-channel instance: the only way to present an out-of-range unicast.
  logic [31:0]  d3_b_in = '0;
  logic         d3_sync = 1'b0;
  logic         d3_notify;
  logic [1:0]   d3_mode = '0;
  logic [1:0]   d3_chan = '0;
  logic [95:0]  d3_b_out;
  logic [2:0]   d3_out_sync = '0;
  logic [2:0]   d3_out_notify;
  logic [2:0]   d3_level;
  logic [15:0]  d3_drop;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  mask;
  } exp_t;

  exp_t       sb_q[$];
  logic [3:0] rem_mask = '0;
  bit         rem_valid = 1'b0;
  logic [1:0] rr_model = '0;

  always #5 clk = ~clk;

  blocking_fanout_buffer #(.DATA_W(32), .NUM_CH(4), .DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .b_in(b_in), .b_in_sync(b_in_sync), .b_in_notify(b_in_notify),
    .m_in_mode(m_in_mode), .m_in_chan(m_in_chan), .b_out(b_out), .b_out_sync(b_out_sync),
    .b_out_notify(b_out_notify), .level(level), .drop_cnt(drop_cnt)
  );

  blocking_fanout_buffer #(.DATA_W(32), .NUM_CH(3), .DEPTH(4)) u_dut3 (
    .clk(clk), .rst(rst), .b_in(d3_b_in), .b_in_sync(d3_sync), .b_in_notify(d3_notify),
    .m_in_mode(d3_mode), .m_in_chan(d3_chan), .b_out(d3_b_out), .b_out_sync(d3_out_sync),
    .b_out_notify(d3_out_notify), .level(d3_level), .drop_cnt(d3_drop)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] model_mask(input logic [1:0] mode, input logic [1:0] chan);
    case (mode)
      2'd0:    return 4'b0001 << chan;
      2'd1:    return 4'b1111;
      2'd2:    return 4'b0001 << rr_model;
      default: return 4'b0000;
    endcase
  endfunction

  // Offer one word, wait (bounded) for the block to be ready, record the
  // expected entry, and release sync right after the accept edge.
  task automatic offer(input logic [31:0] d, input logic [1:0] mode, input logic [1:0] chan);
    int   guard = 0;
    exp_t e;
    b_in = d; m_in_mode = mode; m_in_chan = chan; b_in_sync = 1'b1;
    while (b_in_notify !== 1'b1 && guard < 200) begin
      tick(1);
      guard++;
    end
    chk("accept_wait", 64'(guard < 200), 64'(1));
    e.data = d;
    e.mask = model_mask(mode, chan);
    if (e.mask != 4'b0000) sb_q.push_back(e);
    if (mode == 2'd2) rr_model = (rr_model == 2'd3) ? 2'd0 : rr_model + 2'd1;
    tick(1);
    b_in_sync = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((level !== 3'd0 || b_out_notify !== 4'b0000) && guard < 500) begin
      tick(1);
      guard++;
    end
    chk("idle_wait", 64'(guard < 500), 64'(1));
  endtask

  // Output monitor: notify must equal the head entry's remaining channels,
  // and every handshaking channel must carry the head data.
  always @(negedge clk) begin
    if (rst && b_out_notify !== 4'b0000) begin
      if (sb_q.size() == 0) begin
        chk("spurious_notify", 64'(b_out_notify), 64'(0));
      end else begin
        if (!rem_valid) begin
          rem_mask  = sb_q[0].mask;
          rem_valid = 1'b1;
        end
        chk("notify_vs_expected", 64'(b_out_notify), 64'(rem_mask));
        for (int c = 0; c < 4; c++) begin
          if (b_out_notify[c] && b_out_sync[c]) begin
            chk($sformatf("data_ch%0d", c), 64'(b_out[c*32 +: 32]), 64'(sb_q[0].data));
            rem_mask[c] = 1'b0;
          end
        end
        if (rem_mask == 4'b0000) begin
          exp_t dummy;
          dummy = sb_q.pop_front();
          rem_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    // Reset state
    tick(2);
    chk("rst_in_notify", 64'(b_in_notify), 64'(1));
    chk("rst_out_notify", 64'(b_out_notify), 64'(0));
    chk("rst_b_out", 64'(b_out[63:0]), 64'(0));
    chk("rst_level", 64'(level), 64'(0));
    chk("rst_drop_cnt", 64'(drop_cnt), 64'(0));
    rst = 1'b1;
    tick(1);

    // Unicast to channel 2
    b_out_sync = 4'b0100;
    offer(32'hA5A5_0001, 2'd0, 2'd2);
    chk("uni_level_after_accept", 64'(level), 64'(1));
    chk("uni_notify_same_cycle", 64'(b_out_notify), 64'(0));
    tick(1);
    chk("uni_notify_k1", 64'(b_out_notify), 64'(4'b0100));
    chk("uni_data_ch2", 64'(b_out[95:64]), 64'(32'hA5A5_0001));
    tick(1);
    chk("uni_retired_notify", 64'(b_out_notify), 64'(0));
    chk("uni_retired_level", 64'(level), 64'(0));

    // Broadcast with staggered consumers, a unicast word queued behind it
    b_out_sync = 4'b0000;
    offer(32'h0000_1234, 2'd1, 2'd0);
    offer(32'h0000_5678, 2'd0, 2'd1);
    chk("bc_notify_all", 64'(b_out_notify), 64'(4'b1111));
    chk("bc_level", 64'(level), 64'(2));
    b_out_sync = 4'b0001; tick(1);
    chk("bc_after_ch0", 64'(b_out_notify), 64'(4'b1110));
    b_out_sync = 4'b0100; tick(1);
    chk("bc_after_ch2", 64'(b_out_notify), 64'(4'b1010));
    b_out_sync = 4'b1000; tick(1);
    chk("bc_after_ch3", 64'(b_out_notify), 64'(4'b0010));
    chk("bc_stall_level", 64'(level), 64'(2));
    b_out_sync = 4'b0010; tick(1);
    chk("bc_next_head_notify", 64'(b_out_notify), 64'(4'b0010));
    chk("bc_next_head_data", 64'(b_out[63:32]), 64'(32'h0000_5678));
    chk("bc_retired_level", 64'(level), 64'(1));
    tick(1);
    chk("bc_drained_level", 64'(level), 64'(0));
    b_out_sync = 4'b0000;

    // Round-robin: six words then a seventh that must land on channel 2
    b_out_sync = 4'b1111;
    for (int i = 0; i < 7; i++) offer(32'hB000_0000 + 32'(i), 2'd2, 2'd0);
    wait_idle();
    chk("rr_scoreboard_empty", 64'(sb_q.size()), 64'(0));

    // Fill with all consumers stalled, then release channel 0
    b_out_sync = 4'b0000;
    for (int i = 0; i < 4; i++) offer(32'hF000_0000 + 32'(i), 2'd0, 2'd0);
    chk("full_notify_low", 64'(b_in_notify), 64'(0));
    chk("full_level", 64'(level), 64'(4));
    b_in = 32'hF000_0004; m_in_mode = 2'd0; m_in_chan = 2'd0; b_in_sync = 1'b1;
    tick(2);
    chk("full_stall_level", 64'(level), 64'(4));
    chk("full_stall_notify", 64'(b_in_notify), 64'(0));
    begin
      exp_t e;
      e.data = 32'hF000_0004;
      e.mask = 4'b0001;
      sb_q.push_back(e);
    end
    b_out_sync = 4'b0001;
    tick(1);
    chk("full_release_notify", 64'(b_in_notify), 64'(1));
    chk("full_release_level", 64'(level), 64'(3));
    tick(1);
    b_in_sync = 1'b0;
    chk("full_push_pop_level", 64'(level), 64'(3));
    wait_idle();

    // Drop mode and out-of-range unicast
    b_out_sync = 4'b1111;
    offer(32'hDEAD_0001, 2'd3, 2'd0);
    offer(32'hDEAD_0002, 2'd3, 2'd1);
    tick(1);
    chk("drop_cnt_2", 64'(drop_cnt), 64'(2));
    chk("drop_level", 64'(level), 64'(0));
    chk("drop_no_notify", 64'(b_out_notify), 64'(0));
    d3_b_in = 32'hCAFE_0001; d3_mode = 2'd0; d3_chan = 2'd3; d3_sync = 1'b1;
    tick(1);
    d3_mode = 2'd3;
    tick(1);
    d3_sync = 1'b0;
    tick(1);
    chk("oor_drop_cnt", 64'(d3_drop), 64'(2));
    chk("oor_level", 64'(d3_level), 64'(0));
    chk("oor_no_notify", 64'(d3_out_notify), 64'(0));

    // Saturation of the drop counter
    m_in_mode = 2'd3; b_in_sync = 1'b1;
    tick(65600);
    b_in_sync = 1'b0;
    tick(1);
    chk("drop_saturated", 64'(drop_cnt), 64'(16'hFFFF));

    // Reset in the middle of a pending transfer
    b_out_sync = 4'b0000;
    rr_model = 2'd0;
    for (int i = 0; i < 3; i++) offer(32'hC000_0000 + 32'(i), 2'd0, 2'd3);
    chk("pre_rst_notify", 64'(b_out_notify), 64'(4'b1000));
    chk("pre_rst_level", 64'(level), 64'(3));
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_out_notify", 64'(b_out_notify), 64'(0));
    chk("async_rst_b_out", 64'(b_out[127:96]), 64'(0));
    chk("async_rst_level", 64'(level), 64'(0));
    chk("async_rst_in_notify", 64'(b_in_notify), 64'(1));
    sb_q.delete();
    rem_valid = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
    chk("post_rst_level", 64'(level), 64'(0));
    chk("post_rst_in_notify", 64'(b_in_notify), 64'(1));
    chk("post_rst_out_notify", 64'(b_out_notify), 64'(0));
    chk("post_rst_drop_cnt", 64'(drop_cnt), 64'(0));
    b_out_sync = 4'b1111;
    offer(32'hBEEF_0001, 2'd0, 2'd3);
    wait_idle();
    chk("final_scoreboard_empty", 64'(sb_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
